// File: rtl/cacheline_adapter_pkg.sv
// Shared types and sizes for the cache-line to DRAM-beat adapter.
package cacheline_adapter_pkg;

  localparam int unsigned LINE_W      = 256;
  localparam int unsigned BEAT_W      = 64;
  localparam int unsigned LINE_BEATS  = 4;
  localparam int unsigned OFFSET_BITS = 5;
  localparam int unsigned CNT_W       = $clog2(LINE_BEATS);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR,
    RESP
  } state_e;

endpackage

// File: rtl/cacheline_adapter.sv
// Turns whole-line cache requests into beat-serial DRAM reads/writes.
// Define ADAPTER_RADDR_CHECK_EN to accept read beats only when dram_raddr matches the pending line.
module cacheline_adapter
  import cacheline_adapter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [31:0]       dram_addr,
  output logic              dram_read,
  output logic              dram_write,
  output logic [BEAT_W-1:0] dram_wdata,
  input  logic              dram_ready,
  input  logic [31:0]       dram_raddr,
  input  logic [BEAT_W-1:0] dram_rdata,
  input  logic              dram_rvalid
);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [31:OFFSET_BITS]   addr_q, addr_d;
  logic [LINE_W-1:0]       wdata_buf_q, wdata_buf_d;
  logic [LINE_W-1:0]       line_buf_q, line_buf_d;
  logic                    beat_ok;
  logic                    last_beat;
  logic                    unused_bits;

  always_comb begin
`ifdef ADAPTER_RADDR_CHECK_EN
    beat_ok = dram_rvalid && (dram_raddr[31:OFFSET_BITS] == addr_q);
`else
    beat_ok = dram_rvalid;
`endif
    last_beat   = (beat_cnt_q == CNT_W'(LINE_BEATS - 1));
    unused_bits = ^{dfp_addr[OFFSET_BITS-1:0], dram_raddr};
  end

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    addr_d      = addr_q;
    wdata_buf_d = wdata_buf_q;
    line_buf_d  = line_buf_q;
    case (state_q)
      IDLE: begin
        if (dfp_write) begin
          addr_d      = dfp_addr[31:OFFSET_BITS];
          wdata_buf_d = dfp_wdata;
          beat_cnt_d  = '0;
          state_d     = WR;
        end else if (dfp_read) begin
          addr_d     = dfp_addr[31:OFFSET_BITS];
          beat_cnt_d = '0;
          state_d    = RD_REQ;
        end
      end
      RD_REQ: begin
        if (dram_ready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (beat_ok) begin
          for (int unsigned i = 0; i < LINE_BEATS; i++) begin
            if (beat_cnt_q == CNT_W'(i)) line_buf_d[i*BEAT_W +: BEAT_W] = dram_rdata;
          end
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_beat) state_d = RESP;
        end
      end
      WR: begin
        if (dram_ready) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_beat) state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      addr_q      <= '0;
      wdata_buf_q <= '0;
      line_buf_q  <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      addr_q      <= addr_d;
      wdata_buf_q <= wdata_buf_d;
      line_buf_q  <= line_buf_d;
    end
  end

  // DRAM-side outputs decode from registered state only; nothing here depends on an input.
  always_comb begin
    dram_read  = (state_q == RD_REQ);
    dram_write = (state_q == WR);
    dram_addr  = '0;
    dram_wdata = '0;
    if (state_q == RD_REQ || state_q == WR) dram_addr = {addr_q, {OFFSET_BITS{1'b0}}};
    if (state_q == WR) begin
      for (int unsigned i = 0; i < LINE_BEATS; i++) begin
        if (beat_cnt_q == CNT_W'(i)) dram_wdata = wdata_buf_q[i*BEAT_W +: BEAT_W];
      end
    end
    dfp_resp  = (state_q == RESP);
    dfp_rdata = line_buf_q;
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: reads, writes with stalls, priority, reset abort, idle rvalid.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  dram_addr;
  logic         dram_read;
  logic         dram_write;
  logic [63:0]  dram_wdata;
  logic         dram_ready;
  logic [31:0]  dram_raddr;
  logic [63:0]  dram_rdata;
  logic         dram_rvalid;

  int n_tests = 0;
  int n_fail  = 0;

  cacheline_adapter dut (
    .clk        (clk),
    .rst        (rst),
    .dfp_addr   (dfp_addr),
    .dfp_read   (dfp_read),
    .dfp_write  (dfp_write),
    .dfp_wdata  (dfp_wdata),
    .dfp_rdata  (dfp_rdata),
    .dfp_resp   (dfp_resp),
    .dram_addr  (dram_addr),
    .dram_read  (dram_read),
    .dram_write (dram_write),
    .dram_wdata (dram_wdata),
    .dram_ready (dram_ready),
    .dram_raddr (dram_raddr),
    .dram_rdata (dram_rdata),
    .dram_rvalid(dram_rvalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_line(input logic [31:0] addr, input logic [255:0] line, input bit stray);
    logic [31:0] al;
    al = {addr[31:5], 5'b0};
    dfp_addr    = addr;
    dfp_read    = 1'b1;
    dram_ready  = 1'b1;
    dram_rvalid = 1'b0;
    step();
    check("rd_req_read",  dram_read, 1);
    check("rd_req_addr",  dram_addr, al);
    check("rd_req_write", dram_write, 0);
    step();
    check("rd_data_read", dram_read, 0);
    check("rd_data_addr", dram_addr, 0);
    for (int i = 0; i < 4; i++) begin
      if (stray && i == 2) begin
`ifdef ADAPTER_RADDR_CHECK_EN
        dram_rvalid = 1'b1;
        dram_raddr  = 32'h3000_0000;
        dram_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
        check("rd_stray_no_resp", dfp_resp, 0);
        step();
`endif
      end
      dram_rvalid = 1'b1;
      dram_raddr  = al;
      dram_rdata  = line[i*64 +: 64];
      check("rd_no_resp", dfp_resp, 0);
      step();
    end
    dram_rvalid = 1'b0;
    check("rd_resp", dfp_resp, 1);
    check("rd_line", dfp_rdata, line);
    dfp_read = 1'b0;
    step();
    check("rd_resp_once", dfp_resp, 0);
    check("rd_idle_read", dram_read, 0);
    check("rd_line_hold", dfp_rdata, line);
  endtask

  task automatic write_line(input logic [31:0] addr, input logic [255:0] line, input bit also_read);
    int n;
    bit prev_acc;
    bit done;
    n = 0;
    prev_acc = 1'b0;
    done = 1'b0;
    dfp_addr   = addr;
    dfp_wdata  = line;
    dfp_write  = 1'b1;
    dfp_read   = also_read;
    dram_ready = 1'b0;
    step();
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      check("wr_no_read", dram_read, 0);
      if (dfp_resp) begin
        check("wr_resp_after_last", {prev_acc, n[2:0]}, {1'b1, 3'd4});
        check("wr_resp_wdata_zero", dram_wdata, 0);
        check("wr_resp_write_low", dram_write, 0);
        done = 1'b1;
        dfp_write = 1'b0;
        dfp_read  = 1'b0;
      end else begin
        check("wr_valid", dram_write, 1);
        check("wr_addr", dram_addr, {addr[31:5], 5'b0});
        if (n > 3) check("wr_extra_beat", n, 3);
        else check("wr_beat", dram_wdata, line[n*64 +: 64]);
        dram_ready = (cyc % 2 == 1);
        prev_acc = dram_ready;
        if (dram_ready) n++;
      end
      step();
    end
    if (!done) begin
      check("wr_timeout", 0, 1);
      dfp_write = 1'b0;
      dfp_read  = 1'b0;
      step();
    end
    dram_ready = 1'b0;
    check("wr_resp_once", dfp_resp, 0);
    check("wr_idle_write", dram_write, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    dfp_addr = '0;
    dfp_read = 1'b0;
    dfp_write = 1'b0;
    dfp_wdata = '0;
    dram_ready = 1'b0;
    dram_raddr = '0;
    dram_rdata = '0;
    dram_rvalid = 1'b0;
    step();
    step();
    check("rst_resp",  dfp_resp, 0);
    check("rst_read",  dram_read, 0);
    check("rst_write", dram_write, 0);
    check("rst_addr",  dram_addr, 0);
    check("rst_wdata", dram_wdata, 0);
    check("rst_rdata", dfp_rdata, 0);
    rst = 1'b0;
    step();

    read_line(32'h1000_0024, {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 1'b0);

    write_line(32'h2000_0040, {64'h44, 64'h33, 64'h22, 64'h11}, 1'b0);

    write_line(32'h3000_0060, {64'h88, 64'h77, 64'h66, 64'h55}, 1'b1);
    check("prio_line_untouched", dfp_rdata, {64'hA3, 64'hA2, 64'hA1, 64'hA0});

    // Abort a read after two beats.
    dfp_addr = 32'h1000_0020;
    dfp_read = 1'b1;
    dram_ready = 1'b1;
    step();
    step();
    dram_rvalid = 1'b1;
    dram_raddr = 32'h1000_0020;
    dram_rdata = 64'hB0;
    step();
    dram_rdata = 64'hB1;
    step();
    rst = 1'b1;
    dfp_read = 1'b0;
    dram_rdata = 64'hB2;
    step();
    rst = 1'b0;
    check("abort_resp",  dfp_resp, 0);
    check("abort_read",  dram_read, 0);
    check("abort_write", dram_write, 0);
    check("abort_addr",  dram_addr, 0);
    check("abort_rdata", dfp_rdata, 0);
    dram_rdata = 64'hB3;
    step();
    check("abort_late_resp",  dfp_resp, 0);
    check("abort_late_rdata", dfp_rdata, 0);
    dram_rvalid = 1'b0;
    step();
    check("abort_idle_resp", dfp_resp, 0);
    check("abort_idle_read", dram_read, 0);
    read_line(32'h1000_0020, {64'hC3, 64'hC2, 64'hC1, 64'hC0}, 1'b0);

    // Stray rvalid while idle.
    for (int i = 0; i < 3; i++) begin
      dram_rvalid = 1'b1;
      dram_raddr = 32'h1000_0020;
      dram_rdata = 64'hDEAD_0000 + 64'(i);
      step();
      check("idle_rv_resp",  dfp_resp, 0);
      check("idle_rv_read",  dram_read, 0);
      check("idle_rv_write", dram_write, 0);
      check("idle_rv_rdata", dfp_rdata, {64'hC3, 64'hC2, 64'hC1, 64'hC0});
    end
    dram_rvalid = 1'b0;
    step();

    read_line(32'h1000_0020, {64'hD3, 64'hD2, 64'hD1, 64'hD0}, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
